// File: rtl/multdiv_ctrl.sv
// ---------------------------------------------------------------------------
// multdiv_ctrl
//   Sequences a multi-cycle multiply/divide unit on behalf of a simple
//   in-order pipeline. An R-type mult/div in decode is accepted in IDLE. Its
//   operands, destination and kind are latched. The unit is started with a
//   one-cycle pulse, and the controller waits for md_ready. It then performs
//   a single register-file write: either the result to rd or an exception
//   code to RSTATUS_REG. The upstream pipeline is stalled while the
//   operation is in flight.
//
// Optional feature:
//   MULTDIV_TIMEOUT_EN - adds a WAIT-state watchdog. After TIMEOUT_CYCLES
//   WAIT cycles without md_ready, the controller writes back an exception.
//
// Ports:
//   clock, reset            - single clock, synchronous active-high reset
//   issue_valid, op, alu_op - decode-stage instruction and its encoding
//   rd, data_a, data_b      - destination register and source operands
//   md_result, md_exception,
//   md_ready                - response from the multdiv unit
//   ctrl_mult, ctrl_div     - one-cycle start pulses to the multdiv unit
//   md_operand_a/b          - latched operands presented to the unit
//   stall                   - freezes the upstream pipeline
//   wb_en, wb_reg, wb_data  - register-file write port
// ---------------------------------------------------------------------------
module multdiv_ctrl #(
  parameter int unsigned RSTATUS_REG    = 30,
  parameter int unsigned TIMEOUT_CYCLES = 48
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        issue_valid,
  input  logic [4:0]  op,
  input  logic [4:0]  alu_op,
  input  logic [4:0]  rd,
  input  logic [31:0] data_a,
  input  logic [31:0] data_b,
  input  logic [31:0] md_result,
  input  logic        md_exception,
  input  logic        md_ready,
  output logic        ctrl_mult,
  output logic        ctrl_div,
  output logic [31:0] md_operand_a,
  output logic [31:0] md_operand_b,
  output logic        stall,
  output logic        wb_en,
  output logic [4:0]  wb_reg,
  output logic [31:0] wb_data
);

  localparam logic [4:0]  OP_RTYPE  = 5'b00000;
  localparam logic [4:0]  FN_MULT   = 5'b00110;
  localparam logic [4:0]  FN_DIV    = 5'b00111;
  localparam logic [31:0] CODE_MULT = 32'd4;
  localparam logic [31:0] CODE_DIV  = 32'd5;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2,
    S_WB    = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] op_a_q, op_a_d;
  logic [31:0] op_b_q, op_b_d;
  logic [4:0]  rd_q, rd_d;
  logic        is_div_q, is_div_d;
  logic [31:0] result_q, result_d;
  logic        exc_q, exc_d;
`ifdef MULTDIV_TIMEOUT_EN
  localparam logic [5:0] TIMEOUT_LAST = 6'(TIMEOUT_CYCLES - 1);
  logic [5:0]  cnt_q, cnt_d;
`endif

  logic is_md_op;
  logic accept;

  assign is_md_op = issue_valid && (op == OP_RTYPE) &&
                    ((alu_op == FN_MULT) || (alu_op == FN_DIV));
  // Requests are only taken in IDLE; in the other states the stalled
  // pipeline keeps presenting them until the controller comes back to IDLE.
  assign accept   = is_md_op && (state_q == S_IDLE);

  // Next-state and register update logic.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path
    // can leave one unassigned and infer a latch.
    state_d  = state_q;
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    rd_d     = rd_q;
    is_div_d = is_div_q;
    result_d = result_q;
    exc_d    = exc_q;
`ifdef MULTDIV_TIMEOUT_EN
    cnt_d    = cnt_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d  = S_START;
          op_a_d   = data_a;
          op_b_d   = data_b;
          rd_d     = rd;
          is_div_d = (alu_op == FN_DIV);
        end
      end
      S_START: begin
        // md_ready is deliberately ignored here; the unit has only just
        // been started.
        state_d = S_WAIT;
`ifdef MULTDIV_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      S_WAIT: begin
        if (md_ready) begin
          // A response arriving on the timeout cycle still wins.
          state_d  = S_WB;
          result_d = md_result;
          exc_d    = md_exception;
`ifdef MULTDIV_TIMEOUT_EN
        end else if (cnt_q == TIMEOUT_LAST) begin
          state_d  = S_WB;
          result_d = '0;
          exc_d    = 1'b1;
        end else begin
          cnt_d    = cnt_q + 6'd1;
`endif
        end
      end
      S_WB: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      state_q  <= S_IDLE;
      op_a_q   <= '0;
      op_b_q   <= '0;
      rd_q     <= '0;
      is_div_q <= 1'b0;
      result_q <= '0;
      exc_q    <= 1'b0;
`ifdef MULTDIV_TIMEOUT_EN
      cnt_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      rd_q     <= rd_d;
      is_div_q <= is_div_d;
      result_q <= result_d;
      exc_q    <= exc_d;
`ifdef MULTDIV_TIMEOUT_EN
      cnt_q    <= cnt_d;
`endif
    end
  end

  // Outputs. They are masked by reset so that the whole interface reads
  // zero while reset is held, even before the synchronous reset has taken
  // effect on the state register.
  always_comb begin
    ctrl_mult    = 1'b0;
    ctrl_div     = 1'b0;
    stall        = 1'b0;
    wb_en        = 1'b0;
    wb_reg       = '0;
    wb_data      = '0;
    md_operand_a = '0;
    md_operand_b = '0;
    if (!reset) begin
      md_operand_a = op_a_q;
      md_operand_b = op_b_q;
      unique case (state_q)
        S_IDLE:  stall = accept;
        S_START: begin
          stall     = 1'b1;
          ctrl_mult = !is_div_q;
          ctrl_div  = is_div_q;
        end
        S_WAIT:  stall = 1'b1;
        S_WB: begin
          if (exc_q) begin
            wb_en   = 1'b1;
            wb_reg  = 5'(RSTATUS_REG);
            wb_data = is_div_q ? CODE_DIV : CODE_MULT;
          end else begin
            // A result for r0 is discarded.
            wb_en   = (rd_q != 5'd0);
            wb_reg  = rd_q;
            wb_data = result_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
